// File: rtl/paint_pkg.sv
// Shared definitions for the paint-side arbitration path.
// - Requester index constants (clear / brush / cursor)
// - Default coordinate and pixel widths
// - Arbiter state encoding
// - Helpers: cyclic round-robin index and one-hot to index
package paint_pkg;

  localparam int NUM_REQ    = 3;
  localparam int REQ_CLEAR  = 0;
  localparam int REQ_BRUSH  = 1;
  localparam int REQ_CURSOR = 2;

  localparam int COORD_W_DEF = 6;
  localparam int DATA_W_DEF  = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // k-th requester after 'last' in cyclic order. A pointer of 3 is not
  // reachable in normal operation; it is treated like 2 so requester 0
  // still comes first.
  function automatic logic [1:0] rr_idx(input logic [1:0] last, input int unsigned k);
    int unsigned s;
    s = ((last == 2'd3) ? 32'd2 : 32'(last)) + k;
    return 2'(s % 32'd3);
  endfunction

  function automatic logic [1:0] oh2idx(input logic [2:0] oh);
    logic [1:0] r;
    r = 2'd0;
    if (oh[1]) r = 2'd1;
    if (oh[2]) r = 2'd2;
    return r;
  endfunction

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin pick among three requesters.
// Ports:
//   req   [2:0] in   request bits
//   last  [1:0] in   index of the previously served requester
//   pick  [2:0] out  one-hot winner (first req searching from last+1)
//   valid       out  any request present
module rr_select
  import paint_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] last,
  output logic [2:0] pick,
  output logic       valid
);

  logic [1:0] idx;

  always_comb begin
    pick  = '0;
    valid = 1'b0;
    idx   = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = rr_idx(last, k);
      if (!valid && req[idx]) begin
        pick[idx] = 1'b1;
        valid     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fb_write_arbiter.sv
// Framebuffer write-port arbiter: clear engine (0), brush (1), cursor (2).
// Round-robin grant, burst locking until the holder drops req or reaches
// MAX_BURST accepted writes, then one idle cycle before the next grant.
// Ports:
//   clk, rst (async, active low)
//   req[2:0], src_x/src_y/src_data   packed per-requester pixel
//   gnt[2:0]  registered one-hot grant,  ack[2:0] write accepted (comb)
//   wr_en/wr_x/wr_y/wr_data           framebuffer write, wr_ready backpressure
//   busy                              any grant held
module fb_write_arbiter
  import paint_pkg::*;
#(
  parameter int COORD_W   = COORD_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_BURST = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [2:0]             req,
  input  logic [3*COORD_W-1:0]   src_x,
  input  logic [3*COORD_W-1:0]   src_y,
  input  logic [3*DATA_W-1:0]    src_data,
  output logic [2:0]             gnt,
  output logic [2:0]             ack,
  output logic                   wr_en,
  output logic [COORD_W-1:0]     wr_x,
  output logic [COORD_W-1:0]     wr_y,
  output logic [DATA_W-1:0]      wr_data,
  input  logic                   wr_ready,
  output logic                   busy
);

  localparam logic [7:0] CAP = 8'(MAX_BURST);

  arb_state_e state_q, state_d;
  logic [2:0] gnt_q, gnt_d;
  logic [1:0] last_q, last_d;
  logic [7:0] burst_q, burst_d;

  logic [2:0] pick;
  logic       pick_vld;
  logic [1:0] g;
  logic       req_g, accept, cap_hit;
  logic [7:0] burst_inc;

  logic [2:0][COORD_W-1:0] xs, ys;
  logic [2:0][DATA_W-1:0]  ds;

  assign xs = src_x;
  assign ys = src_y;
  assign ds = src_data;

  rr_select u_rr (
    .req   (req),
    .last  (last_q),
    .pick  (pick),
    .valid (pick_vld)
  );

  assign g         = oh2idx(gnt_q);
  assign req_g     = |(req & gnt_q);
  assign wr_en     = (state_q == GRANT) & req_g;
  assign accept    = wr_en & wr_ready;
  assign ack       = accept ? gnt_q : 3'b000;
  assign burst_inc = burst_q + 8'd1;
  // Compared at 8 bits: the accept that reaches the cap is the last one.
  assign cap_hit   = accept & (burst_inc == CAP);
  assign gnt       = gnt_q;
  assign busy      = |gnt_q;

  // Write mux: all-zero when nothing is granted.
  always_comb begin
    wr_x    = '0;
    wr_y    = '0;
    wr_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_q[i]) begin
        wr_x    = xs[i];
        wr_y    = ys[i];
        wr_data = ds[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    burst_d = burst_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = GRANT;
          gnt_d   = pick;
          burst_d = '0;
        end
      end
      GRANT: begin
        // A req drop and a cap hit on the same edge give one release.
        if (!req_g || cap_hit) begin
          state_d = IDLE;
          gnt_d   = '0;
          last_d  = g;
          burst_d = '0;
        end else if (accept) begin
          burst_d = burst_inc;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        burst_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      last_q  <= 2'd2;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      burst_q <= burst_d;
    end
  end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Randomized + directed bench for fb_write_arbiter against a transaction
// level model (owner / pointer / count integers, per-requester pixel queues).
module tb_fb_write_arbiter;
  import paint_pkg::*;

  localparam int CW = 6;
  localparam int DW = 8;
  localparam int MAXB = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [2:0] req = '0;
  logic [3*CW-1:0] src_x = '0, src_y = '0;
  logic [3*DW-1:0] src_data = '0;
  logic [2:0] gnt, ack;
  logic wr_en, busy;
  logic wr_ready = 1'b1;
  logic [CW-1:0] wr_x, wr_y;
  logic [DW-1:0] wr_data;

  always #5 clk = ~clk;

  fb_write_arbiter #(.COORD_W(CW), .DATA_W(DW), .MAX_BURST(MAXB)) dut (
    .clk(clk), .rst(rst), .req(req), .src_x(src_x), .src_y(src_y),
    .src_data(src_data), .gnt(gnt), .ack(ack), .wr_en(wr_en), .wr_x(wr_x),
    .wr_y(wr_y), .wr_data(wr_data), .wr_ready(wr_ready), .busy(busy)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // producers: queue of pending pixels {x,y,data}; go = request raised
  logic [2*CW+DW-1:0] pend[3][$];
  bit go[3];
  bit rnd = 0;
  bit rdy = 1;

  // reference model
  int owner = -1;
  int ptr = 2;
  int cnt = 0;
  bit m_acc = 0;
  int order[$];
  int dack[3];

  task automatic drive();
    for (int i = 0; i < 3; i++) begin
      if (rnd && pend[i].size() == 0 && $urandom_range(5) == 0)
        repeat ($urandom_range(1, 6)) pend[i].push_back(22'($urandom));
      if (rnd && !go[i] && pend[i].size() > 0 && $urandom_range(2) == 0) go[i] = 1;
      req[i] = go[i] && pend[i].size() > 0;
      if (pend[i].size() > 0)
        {src_x[i*CW +: CW], src_y[i*CW +: CW], src_data[i*DW +: DW]} = pend[i][0];
      else
        {src_x[i*CW +: CW], src_y[i*CW +: CW], src_data[i*DW +: DW]} = 22'($urandom);
    end
    if (rnd) rdy = ($urandom_range(3) != 0);
    wr_ready = rdy;
  endtask

  task automatic check_cycle();
    logic [2:0] eg, ea;
    logic ew;
    logic [2*CW+DW-1:0] exyd;
    eg = '0; ew = 0; exyd = '0;
    if (owner >= 0) begin
      eg = 3'(1 << owner);
      ew = req[owner];
      exyd = {src_x[owner*CW +: CW], src_y[owner*CW +: CW], src_data[owner*DW +: DW]};
    end
    m_acc = ew && wr_ready;
    ea = m_acc ? eg : 3'b0;
    chk("gnt", 32'(gnt), 32'(eg));
    chk("ack", 32'(ack), 32'(ea));
    chk("wr_en", 32'(wr_en), 32'(ew));
    chk("busy", 32'(busy), 32'(owner >= 0));
    chk("wr_xyd", 32'({wr_x, wr_y, wr_data}), 32'(exyd));
    for (int i = 0; i < 3; i++) if (ack[i]) dack[i]++;
  endtask

  task automatic edge_upd();
    if (owner < 0) begin
      for (int k = 1; k <= 3; k++) begin
        int i;
        i = (ptr + k) % 3;
        if (req[i]) begin
          owner = i; cnt = 0; order.push_back(i);
          break;
        end
      end
    end else begin
      if (m_acc) begin
        cnt++;
        void'(pend[owner].pop_front());
      end
      if (!req[owner] || (m_acc && cnt == MAXB)) begin
        ptr = owner; owner = -1; cnt = 0;
      end
    end
    for (int i = 0; i < 3; i++) if (pend[i].size() == 0) go[i] = 0;
  endtask

  task automatic cycle();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    edge_upd();
    #1;
    drive();
  endtask

  task automatic drain(input string tag, input int budget);
    bit idle;
    for (int i = 0; i < 3; i++) if (pend[i].size() > 0) go[i] = 1;
    drive();
    idle = 0;
    for (int n = 0; n < budget; n++) begin
      if (owner < 0 && pend[0].size() == 0 && pend[1].size() == 0 && pend[2].size() == 0) begin
        idle = 1;
        break;
      end
      cycle();
    end
    chk(tag, 32'(idle), 32'd1);
  endtask

  task automatic do_reset_mid();
    #2 rst = 0;
    #1;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    owner = -1; ptr = 2; cnt = 0;
    @(posedge clk);
    #1 rst = 1;
    drive();
  endtask

  task automatic load(input int i, input int n, input logic [2*CW+DW-1:0] first, input logic [2*CW+DW-1:0] step);
    for (int k = 0; k < n; k++) pend[i].push_back(first + 22'(k) * step);
    go[i] = 1;
  endtask

  initial begin
    // reset held with random requests: everything quiet
    for (int n = 0; n < 3; n++) begin
      req = 3'($urandom);
      src_x = 18'($urandom); src_y = 18'($urandom); src_data = 24'($urandom);
      @(negedge clk);
      chk("rst0_gnt", 32'(gnt), 32'd0);
      chk("rst0_wr", 32'({wr_en, ack, busy}), 32'd0);
      chk("rst0_xyd", 32'({wr_x, wr_y, wr_data}), 32'd0);
    end
    @(posedge clk);
    #1 rst = 1;
    rnd = 0; rdy = 1;
    drive();

    // single cursor burst (5,7),(6,7),(7,7) data FF
    dack = '{0, 0, 0};
    order.delete();
    load(REQ_CURSOR, 3, {6'd5, 6'd7, 8'hFF}, {6'd1, 6'd0, 8'd0});
    drain("drain_cursor", 40);
    chk("cursor_acks", 32'(dack[2]), 32'd3);
    chk("cursor_gnt", 32'(order.size() > 0 ? order[0] : -1), 32'd2);

    // all three at once: clear, brush, cursor
    order.delete();
    for (int i = 0; i < 3; i++) load(i, 1, 22'($urandom), 22'd0);
    drain("drain_three", 40);
    chk("three_n", 32'(order.size()), 32'd3);
    for (int k = 0; k < 3; k++) chk("three_ord", 32'(order.size() > k ? order[k] : -1), 32'(k));

    // brush burst stalled 5 cycles after its 2nd accept
    dack = '{0, 0, 0};
    load(REQ_BRUSH, 6, 22'($urandom), 22'h1041);
    drive();
    for (int n = 0; n < 40 && !(owner == 1 && cnt == 2); n++) cycle();
    chk("stall_cnt", 32'(cnt), 32'd2);
    rdy = 0;
    drive();
    repeat (5) cycle();
    rdy = 1;
    drive();
    drain("drain_stall", 60);
    chk("stall_acks", 32'(dack[1]), 32'd6);

    // clear and brush held: alternate bursts of MAXB
    order.delete();
    dack = '{0, 0, 0};
    load(REQ_CLEAR, 3 * MAXB, 22'($urandom), 22'd3);
    load(REQ_BRUSH, 3 * MAXB, 22'($urandom), 22'd5);
    drain("drain_alt", 100);
    chk("alt_n", 32'(order.size()), 32'd6);
    for (int k = 0; k < 6; k++) chk("alt_ord", 32'(order.size() > k ? order[k] : -1), 32'(k % 2));
    chk("alt_acks", 32'(dack[0] + dack[1]), 32'(6 * MAXB));

    // reset during a clear burst, then brush wins over cursor
    load(REQ_CLEAR, 6, 22'($urandom), 22'd1);
    drive();
    for (int n = 0; n < 40 && !(owner == 0 && cnt >= 1); n++) cycle();
    chk("pre_rst_owner", 32'(owner), 32'd0);
    do_reset_mid();
    for (int i = 0; i < 3; i++) begin pend[i].delete(); go[i] = 0; end
    order.delete();
    load(REQ_BRUSH, 1, 22'($urandom), 22'd0);
    load(REQ_CURSOR, 1, 22'($urandom), 22'd0);
    drain("drain_post_rst", 40);
    chk("post_rst_n", 32'(order.size()), 32'd2);
    chk("post_rst_first", 32'(order.size() > 0 ? order[0] : -1), 32'd1);

    // random traffic with random backpressure and one mid-run reset
    rnd = 1;
    drive();
    for (int n = 0; n < 3000; n++) begin
      cycle();
      if (n == 1500) do_reset_mid();
    end
    rnd = 0; rdy = 1;
    drain("drain_rand", 400);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
